// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and parity helper for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_state_t;

    localparam int UART_FRAME_BITS = 11;
    localparam int UART_DATA_BITS  = 8;

    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return ^data ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; tick marks the last cycle of each bit, restart holds it at zero.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    assign tick = cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (restart || tick) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// uart_frame_tx_ctrl: serialises 1-4 bytes of a 32-bit word as back-to-back 11-bit UART frames.
module uart_frame_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [1:0]  num_bytes,
    input  logic        abort,
    output logic        tx,
    output logic        frame_en,
    output logic        busy,
    output logic        done
);

    uart_tx_state_t state, state_d;
    logic [31:0] data;
    logic [1:0]  nb;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [7:0]  cur;
    logic        tick, accept, more;

    assign wr_ready = state == IDLE;
    assign busy     = !wr_ready;
    assign frame_en = busy;
    assign accept   = wr_valid && wr_ready;
    assign cur      = data[{byte_idx, 3'b000} +: 8];
    assign more     = byte_idx < nb;

    // Held at zero in IDLE so the first start bit gets a full period after accept.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (wr_ready || abort),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? START : IDLE;
            START:   state_d = tick ? DATA : START;
            DATA:    state_d = (tick && bit_idx == 3'(UART_DATA_BITS - 1)) ? PAR : DATA;
            PAR:     state_d = tick ? STOP : PAR;
            STOP:    state_d = tick ? (more ? START : IDLE) : STOP;
            default: state_d = IDLE;
        endcase
        if (abort && busy)
            state_d = IDLE;
    end

    always_comb begin
        tx = (state == START) ? 1'b0 :
             (state == DATA)  ? cur[bit_idx] :
             (state == PAR)   ? uart_parity(cur, PARITY_ODD) : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            nb       <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            done     <= 1'b0;
        end else begin
            done <= state == STOP && tick && !more && !abort;
            if (accept || state_d == IDLE) begin
                byte_idx <= '0;
                bit_idx  <= '0;
            end else begin
                if (state == DATA && tick)
                    bit_idx <= bit_idx + 3'd1;
                if (state == STOP && tick && more)
                    byte_idx <= byte_idx + 2'd1;
            end
            if (accept) begin
                data <= wr_data;
                nb   <= num_bytes;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// tb_uart_frame_tx_ctrl: directed checks of framing, parity, back-to-back timing, abort and reset.
module tb_uart_frame_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam logic [10:0] A5_BITS = 11'b10101001010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic [1:0]  num_bytes = '0;
    logic        abort = 1'b0;
    logic        wr_ready, tx, frame_en, busy, done;
    logic        wr_ready_o, tx_o, frame_en_o, busy_o, done_o;
    int          passed = 0;
    int          total = 0;
    int          pulses;

    always #5 clk = ~clk;

    uart_frame_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .num_bytes(num_bytes), .abort(abort), .tx(tx),
        .frame_en(frame_en), .busy(busy), .done(done)
    );

    uart_frame_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_o),
        .wr_data(wr_data), .num_bytes(num_bytes), .abort(abort), .tx(tx_o),
        .frame_en(frame_en_o), .busy(busy_o), .done(done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b, input logic odd);
        if (b == 0)
            return 1'b0;
        if (b <= 8)
            return d[b-1];
        if (b == 9)
            return ^d ^ odd;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle past the accept edge: first START cycle.
    task automatic start(input logic [31:0] d, input logic [1:0] nb);
        wr_valid  = 1'b1;
        wr_data   = d;
        num_bytes = nb;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic frames(input logic [31:0] d, input int nb, input bit hold);
        for (int k = 0; k <= nb; k++)
            for (int b = 0; b < UART_FRAME_BITS; b++)
                for (int c = 0; c < CPB; c++) begin
                    check("tx", tx, exp_bit(d[8*k +: 8], b, 1'b0));
                    check("tx_odd", tx_o, exp_bit(d[8*k +: 8], b, 1'b1));
                    check("frame_en", frame_en, 1);
                    check("busy_odd", busy_o & frame_en_o, 1);
                    check("done_early", done | done_o, 0);
                    if (hold)
                        check("ready_busy", wr_ready, 0);
                    step();
                end
        check("done", done, 1);
        check("done_odd", done_o, 1);
        check("done_ready", wr_ready & wr_ready_o, 1);
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_ready", wr_ready, 1);
        check("rst_frame_en", frame_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        start(32'h0000_00A5, 2'd0);
        check("start_busy", busy, 1);
        check("start_ready", wr_ready, 0);
        for (int b = 0; b < UART_FRAME_BITS; b++)
            for (int c = 0; c < CPB; c++) begin
                check("a5_bit", tx, A5_BITS[b]);
                step();
            end
        check("a5_done", done, 1);
        step();
        check("done_one_cycle", done, 0);

        start(32'h0000_01FF, 2'd1);
        frames(32'h0000_01FF, 1, 1'b0);
        step();

        start(32'h1234_5678, 2'd3);
        wr_valid  = 1'b1;
        wr_data   = 32'hDEAD_BEEF;
        num_bytes = 2'd0;
        frames(32'h1234_5678, 3, 1'b1);
        step();
        wr_valid = 1'b0;
        check("b2b_start", tx, 0);
        frames(32'hDEAD_BEEF, 0, 1'b0);
        step();

        start(32'h0000_00A5, 2'd0);
        repeat (17) step();
        check("pre_abort_tx", tx, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_frame_en", frame_en, 0);
        check("abort_ready", wr_ready, 1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (done || done_o)
                pulses++;
            step();
        end
        check("abort_no_done", pulses, 0);

        abort = 1'b1;
        start(32'h0000_00C3, 2'd0);
        abort = 1'b0;
        frames(32'h0000_00C3, 0, 1'b0);
        step();

        start(32'h0000_00A5, 2'd0);
        repeat (37) step();
        check("par_tx", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", tx, 1);
        check("arst_busy", busy, 0);
        check("arst_frame_en", frame_en, 0);
        check("arst_ready", wr_ready, 1);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_ready", wr_ready, 1);
        check("post_rst_tx", tx, 1);
        check("post_rst_done", done, 0);

        start(32'h0000_003C, 2'd0);
        frames(32'h0000_003C, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
